// File: rtl/comp16_mem_pkg.sv
// Shared constants and types for the comp16 data-memory subsystem.
// Port B of the 64K x 16 data RAM is shared by the requesters listed here.
package comp16_mem_pkg;

   localparam int ADRS_W = 16;
   localparam int DATA_W = 16;

   localparam int REQ_CPU = 0;
   localparam int REQ_DMA = 1;
   localparam int REQ_VID = 2;

   localparam int LOCK_MAX_DEF = 16;

   typedef enum logic {
      LK_FREE,
      LK_HELD
   } lkState_t;

   // Width of an encoded requester index; at least one bit.
   function automatic int idxW(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set mask bit after rrLast,
// wrapping modulo NREQ, wins.
module rr_pick
   import comp16_mem_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int IW   = idxW(NREQ)
) (
   input  logic [NREQ-1:0] reqMask,
   input  logic [IW-1:0]   rrLast,
   output logic [NREQ-1:0] gntOh,
   output logic [IW-1:0]   gntIdx,
   output logic            gntAny
);

   localparam int unsigned NREQ_U = NREQ;

   int unsigned base;
   int unsigned j;
   logic [IW-1:0] jIdx;

   always_comb begin
      gntOh  = '0;
      gntIdx = '0;
      gntAny = 1'b0;
      base   = 32'(rrLast);
      j      = 0;
      jIdx   = '0;
      for (int unsigned k = 1; k <= NREQ_U; k++) begin
         j    = (base + k) % NREQ_U;
         jIdx = IW'(j);
         if (!gntAny && reqMask[jIdx]) begin
            gntAny      = 1'b1;
            gntOh[jIdx] = 1'b1;
            gntIdx      = jIdx;
         end
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing data RAM port B between NREQ requesters, with a
// bounded read-modify-write lock and 1-cycle read-data return routing.
module ram_port_arbiter
   import comp16_mem_pkg::*;
#(
   parameter int NREQ     = 3,
   parameter int LOCK_MAX = LOCK_MAX_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          we,
   input  logic [NREQ*ADRS_W-1:0]   adrs,
   input  logic [NREQ*DATA_W-1:0]   wdata,
   input  logic [NREQ-1:0]          lock,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          rvalid,
   output logic [DATA_W-1:0]        rdata,
   output logic [ADRS_W-1:0]        ram_adrs,
   output logic [DATA_W-1:0]        ram_data,
   output logic                     ram_we,
   input  logic [DATA_W-1:0]        ram_val
);

   localparam int            IW       = idxW(NREQ);
   localparam logic [7:0]    CNT_LAST = 8'(LOCK_MAX - 1);
   localparam logic [7:0]    CNT_SAT  = 8'(LOCK_MAX);
   localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

   logic [IW-1:0]   rrLast;
   lkState_t        lkState, lkStateNext;
   logic [IW-1:0]   lkOwner, lkOwnerNext;
   logic [7:0]      lkCnt, lkCntNext;

   logic [NREQ-1:0] ownerOh, eligible, pickOh;
   logic [IW-1:0]   pickIdx;
   logic            pickAny, xfer;

   // While locked, only the owner is presented to the picker.
   always_comb begin
      ownerOh          = '0;
      ownerOh[lkOwner] = 1'b1;
      eligible         = (lkState == LK_HELD) ? (req & ownerOh) : req;
   end

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) picker (
      .reqMask (eligible),
      .rrLast  (rrLast),
      .gntOh   (pickOh),
      .gntIdx  (pickIdx),
      .gntAny  (pickAny)
   );

   assign xfer     = pickAny & ~rst;
   assign gnt      = xfer ? pickOh : '0;
   assign ram_we   = xfer & we[pickIdx];
   assign ram_adrs = xfer ? adrs[pickIdx*ADRS_W +: ADRS_W] : '0;
   assign ram_data = xfer ? wdata[pickIdx*DATA_W +: DATA_W] : '0;
   assign rdata    = ram_val;

   always_comb begin
      lkStateNext = lkState;
      lkOwnerNext = lkOwner;
      lkCntNext   = lkCnt;
      unique case (lkState)
         LK_FREE: begin
            if (xfer && lock[pickIdx]) begin
               lkStateNext = LK_HELD;
               lkOwnerNext = pickIdx;
               lkCntNext   = '0;
            end
         end
         LK_HELD: begin
            if (!lock[lkOwner] || lkCnt == CNT_LAST) begin
               lkStateNext = LK_FREE;
               lkCntNext   = '0;
            end else if (lkCnt != CNT_SAT) begin
               // Release at CNT_LAST normally pre-empts saturation.
               lkCntNext = lkCnt + 8'd1;
            end
         end
         default: lkStateNext = LK_FREE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rrLast  <= LAST_RST;
         lkState <= LK_FREE;
         lkOwner <= '0;
         lkCnt   <= '0;
         rvalid  <= '0;
      end else begin
         if (xfer) rrLast <= pickIdx;
         lkState <= lkStateNext;
         lkOwner <= lkOwnerNext;
         lkCnt   <= lkCntNext;
         rvalid  <= gnt & ~we;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, per-cycle reference model and
// directed scenarios with literal expectations.
module tb_ram_port_arbiter;
   import comp16_mem_pkg::*;

   localparam int NREQ     = 3;
   localparam int LOCK_MAX = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req = '0, we = '0, lock = '0;
   logic [47:0] adrs = '0, wdata = '0;
   logic [2:0]  gnt, rvalid;
   logic [15:0] rdata, ram_adrs, ram_data, ram_val;
   logic        ram_we;

   int nChecks = 0;
   int nErr    = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(
      .NREQ     (NREQ),
      .LOCK_MAX (LOCK_MAX)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .we       (we),
      .adrs     (adrs),
      .wdata    (wdata),
      .lock     (lock),
      .gnt      (gnt),
      .rvalid   (rvalid),
      .rdata    (rdata),
      .ram_adrs (ram_adrs),
      .ram_data (ram_data),
      .ram_we   (ram_we),
      .ram_val  (ram_val)
   );

   function automatic logic [15:0] pre(input logic [15:0] a);
      return a ^ 16'hA5C3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setSlice(input int i, input logic [15:0] a, input logic [15:0] d);
      adrs[16*i +: 16]  = a;
      wdata[16*i +: 16] = d;
   endtask

   // Synchronous RAM, registered read of the pre-write contents.
   logic [15:0] mem [0:65535];
   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = pre(16'(a));
      ram_val = '0;
      forever begin
         @(posedge clk);
         ram_val <= mem[ram_adrs];
         if (ram_we) mem[ram_adrs] = ram_data;
      end
   end

   // Reference model: pointer, lock owner and locked-cycle count as integers.
   logic [15:0] expMem [0:65535];
   int          mLast, mOwner, mAge, gi;
   bit          mLocked;
   logic [2:0]  mRvPend, eg;
   logic [15:0] mRdPend;
   logic        ewe;

   initial begin
      for (int a = 0; a < 65536; a++) expMem[a] = pre(16'(a));
      mLast = NREQ - 1; mOwner = 0; mAge = 0; mLocked = 0;
      mRvPend = '0; mRdPend = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mLast = NREQ - 1; mLocked = 0; mAge = 0; mRvPend = '0;
            check("m_rst_gnt", 32'(gnt), 32'h0);
            check("m_rst_we", 32'(ram_we), 32'h0);
            check("m_rst_rvalid", 32'(rvalid), 32'h0);
         end else begin
            gi = -1;
            if (mLocked) begin
               if (req[mOwner]) gi = mOwner;
            end else begin
               for (int k = 1; k <= NREQ; k++)
                  if (gi < 0 && req[(mLast + k) % NREQ]) gi = (mLast + k) % NREQ;
            end
            eg = '0;
            if (gi >= 0) eg[gi] = 1'b1;
            ewe = (gi >= 0) ? we[gi] : 1'b0;
            check("m_gnt", 32'(gnt), 32'(eg));
            check("m_rvalid", 32'(rvalid), 32'(mRvPend));
            if (mRvPend != 0) check("m_rdata", 32'(rdata), 32'(mRdPend));
            check("m_ram_we", 32'(ram_we), 32'(ewe));
            if (gi >= 0) begin
               check("m_ram_adrs", 32'(ram_adrs), 32'(adrs[16*gi +: 16]));
               check("m_ram_data", 32'(ram_data), 32'(wdata[16*gi +: 16]));
            end else if (req == 0) begin
               check("m_idle_adrs", 32'(ram_adrs), 32'h0);
               check("m_idle_data", 32'(ram_data), 32'h0);
            end
            mRvPend = '0;
            if (gi >= 0) begin
               mLast = gi;
               if (we[gi]) expMem[adrs[16*gi +: 16]] = wdata[16*gi +: 16];
               else begin
                  mRvPend[gi] = 1'b1;
                  mRdPend     = expMem[adrs[16*gi +: 16]];
               end
            end
            if (mLocked) begin
               mAge++;
               if (!lock[mOwner] || mAge == LOCK_MAX) mLocked = 0;
            end else if (gi >= 0 && lock[gi]) begin
               mLocked = 1; mOwner = gi; mAge = 0;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < NREQ; i++) setSlice(i, 16'h0100 + 16'(i), 16'h0);
      req = 3'b111;
      repeat (3) step();
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_ram_we", 32'(ram_we), 32'h0);
      check("rst_rvalid", 32'(rvalid), 32'h0);

      // Round-robin reads out of reset.
      rst = 1'b0;
      #2 check("rr_gnt0", 32'(gnt), 32'h1);
      check("rr_rv_none", 32'(rvalid), 32'h0);
      step(); #2 check("rr_gnt1", 32'(gnt), 32'h2);
      check("rr_rv0", 32'(rvalid), 32'h1);
      check("rr_rd0", 32'(rdata), 32'(pre(16'h0100)));
      step(); #2 check("rr_gnt2", 32'(gnt), 32'h4);
      check("rr_rv1", 32'(rvalid), 32'h2);
      check("rr_rd1", 32'(rdata), 32'(pre(16'h0101)));
      step(); req = 3'b000;
      #2 check("rr_idle_gnt", 32'(gnt), 32'h0);
      check("rr_rv2", 32'(rvalid), 32'h4);
      check("rr_rd2", 32'(rdata), 32'(pre(16'h0102)));

      // Write then same-address read by another requester.
      step(); req = 3'b001; we = 3'b001; setSlice(REQ_CPU, 16'h1234, 16'hBEEF);
      #2 check("wr_gnt", 32'(gnt), 32'h1);
      check("wr_we", 32'(ram_we), 32'h1);
      check("wr_adrs", 32'(ram_adrs), 32'h1234);
      check("wr_data", 32'(ram_data), 32'hBEEF);
      step(); req = 3'b010; we = 3'b000; setSlice(REQ_DMA, 16'h1234, 16'h0);
      #2 check("rd_gnt", 32'(gnt), 32'h2);
      check("rd_we", 32'(ram_we), 32'h0);
      step(); req = 3'b000;
      #2 check("rd_rvalid", 32'(rvalid), 32'h2);
      check("rd_rdata", 32'(rdata), 32'hBEEF);

      // Voluntary lock by requester 1.
      step(); req = 3'b010; lock = 3'b010; setSlice(REQ_DMA, 16'h2000, 16'h0);
      #2 check("lk_acq", 32'(gnt), 32'h2);
      setSlice(REQ_VID, 16'h2002, 16'h0);
      repeat (4) begin
         step(); req = 3'b110;
         #2 check("lk_hold", 32'(gnt), 32'h2);
      end
      step(); lock = 3'b000;
      #2 check("lk_release_edge", 32'(gnt), 32'h2);
      step(); #2 check("lk_after", 32'(gnt), 32'h4);
      step(); req = 3'b000;

      // Forced release after LOCK_MAX locked cycles.
      for (int c = 0; c < 40; c++) begin
         step();
         req  = (c <= 17) ? 3'b011 : 3'b001;
         lock = 3'b001;
         setSlice(REQ_CPU, 16'h3000 + 16'(c), 16'h0);
         #2;
         if (c <= 16) check("fl_hold", 32'(gnt), 32'h1);
         else if (c == 17) check("fl_forced", 32'(gnt), 32'h2);
      end
      step(); req = 3'b000; lock = 3'b000;
      step();

      // Async reset drops an outstanding read.
      step(); req = 3'b100; we = 3'b000; setSlice(REQ_VID, 16'h0300, 16'h0);
      #2 check("ar_gnt", 32'(gnt), 32'h4);
      #5 rst = 1'b1;
      step(); req = 3'b000;
      #2 check("ar_rvalid", 32'(rvalid), 32'h0);
      check("ar_gnt_rst", 32'(gnt), 32'h0);
      check("ar_we_rst", 32'(ram_we), 32'h0);
      step(); rst = 1'b0; req = 3'b111; setSlice(REQ_CPU, 16'h0400, 16'h0);
      #2 check("ar_first", 32'(gnt), 32'h1);
      step(); req = 3'b000;
      #2 check("ar_rv", 32'(rvalid), 32'h1);
      check("ar_rd", 32'(rdata), 32'(pre(16'h0400)));

      // Idle bus.
      repeat (10) begin
         step();
         #2 check("idle_gnt", 32'(gnt), 32'h0);
         check("idle_rvalid", 32'(rvalid), 32'h0);
         check("idle_we", 32'(ram_we), 32'h0);
         check("idle_adrs", 32'(ram_adrs), 32'h0);
      end
      step();
      $display("Result: errors=%0d of %0d checks", nErr, nChecks);
      $finish;
   end

endmodule
